// File: rtl/sub_shift_rows_seq.sv
// Iterative AES SubBytes + ShiftRows stage: LANES shared S-boxes per cycle, held output.
// Optional SUBSHIFT_INV_EN adds an 'inv' port selecting InvSubBytes + InvShiftRows.
module sub_shift_rows_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
`ifdef SUBSHIFT_INV_EN
    ,
    input  logic         inv
`endif
);

    localparam int unsigned NCYC  = 16 / LANES;
    localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       w_q [16];
    logic [7:0]       w_d [16];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic [3:0]       lane_idx [LANES];
    logic [7:0]       lane_out [LANES];
    logic [127:0]     shifted;
`ifdef SUBSHIFT_INV_EN
    logic             inv_q, inv_d;
`endif

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

`ifdef SUBSHIFT_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction
`endif

    // Source byte for output byte n (n = 4*col + row) under (Inv)ShiftRows
    function automatic logic [3:0] sr_src(input int unsigned n, input logic inv_sel);
        int unsigned c;
        int unsigned r;
        c = n / 4;
        r = n % 4;
        return inv_sel ? 4'(4 * ((c + 4 - r) % 4) + r) : 4'(4 * ((c + r) % 4) + r);
    endfunction

    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Shared S-box bank: lane l handles byte cnt*LANES + l
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(32'(cnt_q) * LANES + l);
`ifdef SUBSHIFT_INV_EN
            lane_out[l] = inv_q ? sbox_inv(w_q[lane_idx[l]]) : sbox_fwd(w_q[lane_idx[l]]);
`else
            lane_out[l] = sbox_fwd(w_q[lane_idx[l]]);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
`ifdef SUBSHIFT_INV_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            IDLE: ;
            SUB: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    w_d[lane_idx[l]] = lane_out[l];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Accept overrides: covers both IDLE and the back-to-back DONE handoff
        if (accept) begin
            for (int unsigned n = 0; n < 16; n++) begin
                w_d[4'(n)] = 8'(state_in >> (8 * (15 - n)));
            end
            cnt_d   = '0;
            state_d = SUB;
`ifdef SUBSHIFT_INV_EN
            inv_d   = inv;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '{default: 8'h00};
`ifdef SUBSHIFT_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
`ifdef SUBSHIFT_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    always_comb begin
        shifted = '0;
        for (int unsigned n = 0; n < 16; n++) begin
`ifdef SUBSHIFT_INV_EN
            shifted = {shifted[119:0], w_q[sr_src(n, inv_q)]};
`else
            shifted = {shifted[119:0], w_q[sr_src(n, 1'b0)]};
`endif
        end
    end

    assign out_valid = (state_q == DONE);
    assign state_out = out_valid ? shifted : '0;

endmodule

// File: tb/tb_sub_shift_rows_seq.sv
// Scoreboard bench for sub_shift_rows_seq; reference S-boxes generated from the GF(2^8) generator walk.
module tb_sub_shift_rows_seq;

    localparam int unsigned LANES = 4;
    localparam int unsigned NCYC  = 16 / LANES;
    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ALL_63   = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
`ifdef SUBSHIFT_INV_EN
    logic         inv_r;
`endif

    always #5 clk = ~clk;

    sub_shift_rows_seq #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
`ifdef SUBSHIFT_INV_EN
        ,
        .inv       (inv_r)
`endif
    );

    typedef struct {
        logic [127:0] data;
        int unsigned  acc_edge;
        bit           seen;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp  = 0;
    int unsigned n_err  = 0;
    int unsigned edge_n = 0;
    logic [7:0]  sbox  [256];
    logic [7:0]  isbox [256];
    bit          rnd_done = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walk p over powers of 3 and q over powers of 3^-1, so q = p^-1 at every step
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ 8'(q << 1);
            q = q ^ 8'(q << 2);
            q = q ^ 8'(q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_out(input logic [127:0] d, input bit iv);
        logic [127:0] o;
        logic [7:0]   b;
        int           c, r, sc;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            c  = n / 4;
            r  = n % 4;
            sc = iv ? (c - r + 4) % 4 : (c + r) % 4;
            b  = 8'(d >> (8 * (15 - (4 * sc + r))));
            o  = {o[119:0], (iv ? isbox[b] : sbox[b])};
        end
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input bit iv, input logic [127:0] exp,
                        output int unsigned acc);
        bit ok;
        ok  = 0;
        acc = 0;
        in_valid = 1'b1;
        state_in = d;
`ifdef SUBSHIFT_INV_EN
        inv_r = iv;
`endif
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = edge_n + 1;
                sb.push_back('{data: exp, acc_edge: acc, seen: 1'b0});
                ok = 1;
            end
            step();
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready never rose for state %h", d);
        end
        in_valid = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (sb.size() == 0) ok = 1;
            else step();
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
        end
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL valid_timeout: out_valid never rose");
        end
    endtask

    // Monitor: checks latency on first appearance and data on every handshake
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: out_valid=1 with nothing outstanding, state_out=%h",
                         state_out);
            end else begin
                if (!sb[0].seen) begin
                    sb[0].seen = 1;
                    check("latency", 128'(edge_n - sb[0].acc_edge), 128'(NCYC));
                end
                if (out_ready) begin
                    check("state_out", state_out, sb[0].data);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int unsigned a1, a2, dummy;
        logic [127:0] d;
        bit           iv;

        build_sbox();
        rst       = 1'b1;
        in_valid  = 1'b0;
        state_in  = '0;
        out_ready = 1'b0;
`ifdef SUBSHIFT_INV_EN
        inv_r     = 1'b0;
`endif
        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_state_out", state_out, '0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 128'(in_ready), 128'(1));
        step();

        // Known-answer forward round
        out_ready = 1'b1;
        send(APPB_IN, 0, APPB_OUT, dummy);
        drain();

        // All-zero input; in_ready low for every SUB cycle
        send('0, 0, ALL_63, dummy);
        for (int i = 0; i < int'(NCYC); i++) begin
            @(negedge clk);
            check("in_ready_sub", 128'(in_ready), 128'(0));
        end
        step();
        drain();

        // Backpressure: output held, input refused
        out_ready = 1'b0;
        send(APPB_IN, 0, APPB_OUT, dummy);
        wait_valid();
        step();
        in_valid = 1'b1;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_state_out", state_out, APPB_OUT);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_release", 128'(out_valid), 128'(0));
        step();

        // Back-to-back handoff with no idle bubble
        out_ready = 1'b1;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 0, ref_out(d, 0), a1);
        send('0, 0, ALL_63, a2);
        check("b2b_gap", 128'(a2 - a1), 128'(NCYC + 1));
        drain();

        // Reset during the second SUB cycle discards the transfer
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 0, ref_out(d, 0), dummy);
        step();
        rst = 1'b1;
        step();
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_state_out", state_out, '0);
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_after", 128'(in_ready), 128'(1));
        step();
        repeat (2 * NCYC + 4) step();

`ifdef SUBSHIFT_INV_EN
        // Known-answer inverse round
        send(APPB_OUT, 1, APPB_IN, dummy);
        drain();
`endif

        // Randomized traffic with random consumer stalls
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    d  = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUBSHIFT_INV_EN
                    iv = 1'($urandom_range(0, 1));
`else
                    iv = 0;
`endif
                    send(d, iv, ref_out(d, iv), dummy);
                    repeat ($urandom_range(0, 2)) step();
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
        join
        out_ready = 1'b1;
        drain();
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub_shift_rows_seq.md
Name: sub_shift_rows_seq

Overview:
- Iterative SubBytes + ShiftRows stage of the AES-128 round datapath.
- Sits directly upstream of the combinational MixColumns stage; its state_out feeds MixColumns state_in.
- Accepts one 128-bit state via valid/ready and substitutes LANES bytes per cycle through a shared S-box bank.
- Presents the ShiftRows-permuted result on a registered, held output until the consumer accepts it.

Parameters:
- LANES, 4: S-box instances used per cycle. Legal values are 1, 2, 4, 8, 16. SUB phase takes NCYC = 16/LANES cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state this cycle
- state_in  input  128  input state, column-major
- out_valid  output  1  state_out is valid
- out_ready  input  1  consumer accepts state_out
- state_out  output  128  SubBytes+ShiftRows result, column-major

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is rst, synchronous and active-high.
- Byte map, for both ports:
  - byte n = 4*c + r, where c is column and r is row.
  - byte n occupies bits [127-8n -: 8], so row 0 of column 0 is bits 127:120.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - in_ready = 1.
  - On accept, latch state_in into work register W, set cnt = 0, go to SUB.
- SUB:
  - in_ready = 0.
  - Each cycle, replace W bytes cnt*LANES .. cnt*LANES+LANES-1 with their S-box values (FIPS-197 forward S-box) and increment cnt.
  - After the cycle with cnt = NCYC-1, go to DONE.
- DONE:
  - out_valid = 1.
  - state_out = ShiftRows(W), where out[r][c] = W[r][(c+r) mod 4].
  - W is held stable while out_ready = 0.
  - out_ready = 1 and in_valid = 0: go to IDLE.
- Back-to-back: in DONE, in_ready = out_ready. If out_ready && in_valid on the same edge, the output is consumed and the new state is latched; go directly to SUB with cnt = 0 and no idle bubble.
- Latency: accept on edge k gives out_valid = 1 after edge k+NCYC (4 cycles at LANES=4). Throughput is one state per NCYC+1 cycles with back-to-back handshaking.
- No combinational path from in_valid to in_ready. in_ready depends only on state and out_ready.
- in_valid is ignored when in_ready = 0. state_in is only sampled on accept.
- cnt width is clog2(NCYC), minimum 1 bit. With LANES=16, SUB lasts exactly 1 cycle.
- Reset, including mid-SUB or mid-DONE:
  - Next state IDLE, W = 0, cnt = 0.
  - out_valid = 0, state_out = 0.
  - in_ready is forced to 0 while rst = 1 and is 1 on the first cycle after rst is released.
  - Any in-flight state is discarded.

Optional Feature:
- Macro: SUBSHIFT_INV_EN.
- Defined:
  - Adds port inv (input, 1 bit), sampled on accept and held in a register for the whole operation.
  - inv = 1 selects the inverse S-box in SUB and InvShiftRows in DONE: out[r][c] = W[r][(c-r) mod 4].
  - inv = 0 gives the forward behaviour.
  - The inv register resets to 0.
- Undefined: no inv port; forward-only operation, and only the forward S-box bank is synthesised.

Test Plan:
- FIPS-197 App. B round 1, forward path:
  - Stimulus: accept state_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808 with out_ready = 1.
  - Response: out_valid = 1 exactly 4 cycles after accept (LANES=4), state_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5.
- All-zero input:
  - Stimulus: state_in = 0.
  - Response: state_out = 128'h6363...63 (all 16 bytes 8'h63). in_ready = 0 throughout SUB.
- Output backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid rises.
  - Response: state_out is unchanged, out_valid stays 1, and in_ready = 0 with in_valid = 1 applied.
  - Then pulse out_ready = 1: out_valid = 0 the next cycle.
- Back-to-back:
  - Stimulus: in DONE, assert out_ready = 1 and in_valid = 1 with state_in = 0 on the same edge.
  - Response: the first result is consumed, SUB starts the next cycle, and the second result 128'h63...63 is valid 4 cycles later.
- Reset mid-operation:
  - Stimulus: assert rst during SUB cycle 2 of a transfer.
  - Response: next cycle out_valid = 0 and state_out = 0. After rst is released, in_ready = 1 and no stale output ever appears.
- SUBSHIFT_INV_EN, inverse path:
  - Stimulus: inv = 1, state_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5.
  - Response: state_out = 128'h193de3bea0f4e22b9ac68d2ae9f84808.
  - Repeat the App. B forward-path case with LANES=1: out_valid rises 16 cycles after accept, same expected output.
